pll_scan_readback: RTL and testbench

//  Reads back the PLL reconfiguration scan chain (the reader to the reconfig writer). Clocks the chain

---
 rtl/pll_scan_pkg.sv | 17 +
 rtl/pll_scan_readback_crc16.sv | 29 ++
 rtl/pll_scan_readback.sv | 153 +++++++++++++++
 tb/tb_pll_scan_readback.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_scan_pkg.sv
// Shared types and constants for the PLL scan-chain readback block.
package pll_scan_pkg;

   localparam int unsigned PLL_CHAIN_LEN = 144;
   localparam logic [15:0] CRC_POLY      = 16'h1021;
   localparam logic [15:0] CRC_INIT      = 16'hFFFF;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_REQ      = 3'd1,
      S_SHIFT_LO = 3'd2,
      S_SHIFT_HI = 3'd3,
      S_HOLD     = 3'd4,
      S_FIN      = 3'd5
   } state_t;

endpackage

// File: rtl/pll_scan_readback_crc16.sv
// Bit-serial CRC-16/CCITT over the captured scan bits; built only with PLL_READBACK_CRC_EN.
`ifdef PLL_READBACK_CRC_EN
module pll_scan_crc16
   import pll_scan_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        i_init,
   input  logic        i_en,
   input  logic        i_din,
   output logic [15:0] o_crc
);

   logic        w_fb;
   logic [15:0] w_crc_nxt;

   always_comb begin
      w_fb      = o_crc[15] ^ i_din;
      w_crc_nxt = {o_crc[14:0], 1'b0} ^ (w_fb ? CRC_POLY : 16'h0000);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)    o_crc <= CRC_INIT;
      else if (i_init) o_crc <= CRC_INIT;
      else if (i_en)   o_crc <= w_crc_nxt;
   end

endmodule
`endif

// File: rtl/pll_scan_readback.sv
// Reads back the PLL reconfig scan chain, recirculating each bit, and emits LSB-first bytes.
// Optional CRC-16 output enabled by defining PLL_READBACK_CRC_EN.
module pll_scan_readback
   import pll_scan_pkg::*;
#(
   parameter int unsigned CHAIN_LEN   = PLL_CHAIN_LEN,
   parameter int unsigned SCANCLK_DIV = 2
)
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        scan_req,
   input  logic        scan_gnt,
   output logic        scanclk,
   output logic        scanclkena,
   output logic        scandata,
   input  logic        scandataout,
   output logic [7:0]  byte_data,
   output logic        byte_valid,
   input  logic        byte_ready
`ifdef PLL_READBACK_CRC_EN
   ,
   output logic [15:0] crc
`endif
);

   localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int unsigned DIV_W = (SCANCLK_DIV > 1) ? $clog2(SCANCLK_DIV) : 1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_abort;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [DIV_W-1:0] r_div;
   logic [2:0]       r_bidx;
   logic [7:0]       r_sr;

   logic w_div_first;
   logic w_div_last;
   logic w_last_bit;
   logic w_all_done;
   logic w_accept;
   logic w_start_acc;
   logic w_sample;
   logic w_bit_end;
   logic w_nxt_shift;

   always_comb begin
      w_div_first = (r_div == '0);
      w_div_last  = (r_div == DIV_W'(SCANCLK_DIV - 1));
      w_last_bit  = (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));
      w_all_done  = (r_bit_cnt == CNT_W'(CHAIN_LEN));
      w_accept    = byte_valid && byte_ready;
      w_start_acc = (r_state == S_IDLE) && start;
      w_sample    = (r_state == S_SHIFT_LO) && w_div_last;
      w_bit_end   = (r_state == S_SHIFT_HI) && w_div_last && scan_gnt;
      w_nxt_shift = (w_state_nxt == S_SHIFT_LO) || (w_state_nxt == S_SHIFT_HI);
   end

   // Next-state logic; losing the grant anywhere in the shift/hold phase aborts via FIN.
   always_comb begin
      w_state_nxt = r_state;
      w_abort     = 1'b0;
      case (r_state)
         S_IDLE:     if (start) w_state_nxt = S_REQ;
         S_REQ:      if (scan_gnt) w_state_nxt = S_SHIFT_LO;
         S_SHIFT_LO: begin
            if (!scan_gnt)       w_abort = 1'b1;
            else if (w_div_last) w_state_nxt = S_SHIFT_HI;
         end
         S_SHIFT_HI: begin
            if (!scan_gnt)       w_abort = 1'b1;
            else if (w_div_last) w_state_nxt = (w_last_bit || (r_bidx == 3'd7)) ? S_HOLD : S_SHIFT_LO;
         end
         S_HOLD: begin
            if (!scan_gnt)     w_abort = 1'b1;
            else if (w_accept) w_state_nxt = w_all_done ? S_FIN : S_SHIFT_LO;
         end
         S_FIN:      w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
      if (w_abort) w_state_nxt = S_FIN;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Registered outputs decoded from the next state, plus the shift datapath.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         scan_req   <= 1'b0;
         scanclk    <= 1'b0;
         scanclkena <= 1'b0;
         scandata   <= 1'b0;
         byte_data  <= 8'h00;
         byte_valid <= 1'b0;
         r_div      <= '0;
         r_bit_cnt  <= '0;
         r_bidx     <= 3'd0;
         r_sr       <= 8'h00;
      end else begin
         busy       <= (w_state_nxt != S_IDLE);
         done       <= (w_state_nxt == S_FIN);
         scan_req   <= (w_state_nxt == S_REQ) || w_nxt_shift || (w_state_nxt == S_HOLD);
         scanclk    <= (w_state_nxt == S_SHIFT_HI);
         scanclkena <= w_nxt_shift;
         byte_valid <= (w_state_nxt == S_HOLD);
         r_div      <= (w_state_nxt != r_state) ? '0 : r_div + DIV_W'(1);

         if (w_start_acc) begin
            error     <= 1'b0;
            r_bit_cnt <= '0;
            r_bidx    <= 3'd0;
            r_sr      <= 8'h00;
         end else if (w_abort) begin
            error <= 1'b1;
         end

         // Feed the bit now on scandataout back in so the chain ends where it started.
         if ((r_state == S_SHIFT_LO) && w_div_first) scandata <= scandataout;
         if (w_sample) r_sr[r_bidx] <= scandataout;

         if (w_bit_end) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            r_bidx    <= r_bidx + 3'd1;
         end

         if ((r_state == S_SHIFT_HI) && (w_state_nxt == S_HOLD)) byte_data <= r_sr;
         if ((r_state == S_HOLD) && (w_state_nxt == S_SHIFT_LO)) r_sr <= 8'h00;
      end
   end

`ifdef PLL_READBACK_CRC_EN
   pll_scan_crc16 u_crc (
      .clock   (clock),
      .reset_n (reset_n),
      .i_init  (w_start_acc),
      .i_en    (w_sample),
      .i_din   (scandataout),
      .o_crc   (crc)
   );
`endif

endmodule

// File: tb/tb_pll_scan_readback.sv
// Bench for pll_scan_readback: behavioural scan chains, directed and randomized readbacks.
module tb_pll_scan_readback;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Main DUT: 144-bit chain
   logic        start, busy, done, error, scan_req, scan_gnt, scanclk, scanclkena, scandata, scandataout;
   logic [7:0]  byte_data;
   logic        byte_valid, byte_ready;
   logic        gnt_en;
   logic [143:0] chain, load_val;
   logic        load_req;
   int          edge_cnt;

   // Second DUT: 12-bit chain
   logic        start12, busy12, done12, error12, req12, sclk12, sena12, sdata12, sdout12;
   logic [7:0]  bdata12;
   logic        bvalid12, bready12;
   logic [11:0] chain12, load_val12;
   logic        load_req12;
   int          edge_cnt12;
   int          hold_viol = 0;

`ifdef PLL_READBACK_CRC_EN
   logic [15:0] crc, crc12;
`endif

   pll_scan_readback #(.CHAIN_LEN(144), .SCANCLK_DIV(2)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done), .error(error),
      .scan_req(scan_req), .scan_gnt(scan_gnt), .scanclk(scanclk), .scanclkena(scanclkena),
      .scandata(scandata), .scandataout(scandataout), .byte_data(byte_data),
      .byte_valid(byte_valid), .byte_ready(byte_ready)
`ifdef PLL_READBACK_CRC_EN
      , .crc(crc)
`endif
   );

   pll_scan_readback #(.CHAIN_LEN(12), .SCANCLK_DIV(3)) dut12 (
      .clock(clock), .reset_n(reset_n), .start(start12), .busy(busy12), .done(done12), .error(error12),
      .scan_req(req12), .scan_gnt(req12), .scanclk(sclk12), .scanclkena(sena12),
      .scandata(sdata12), .scandataout(sdout12), .byte_data(bdata12),
      .byte_valid(bvalid12), .byte_ready(bready12)
`ifdef PLL_READBACK_CRC_EN
      , .crc(crc12)
`endif
   );

   // External mux model: grant follows request one cycle later while enabled
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) scan_gnt <= 1'b0;
      else          scan_gnt <= scan_req & gnt_en;
   end

   // Scan chain models: bit 0 is on scandataout, shift toward it on rising scanclk
   assign scandataout = chain[0];
   always @(posedge scanclk or posedge load_req) begin
      if (load_req) begin
         chain <= load_val; edge_cnt <= 0;
      end else if (scanclkena) begin
         chain <= {scandata, chain[143:1]}; edge_cnt <= edge_cnt + 1;
      end
   end

   assign sdout12 = chain12[0];
   always @(posedge sclk12 or posedge load_req12) begin
      if (load_req12) begin
         chain12 <= load_val12; edge_cnt12 <= 0;
      end else if (sena12) begin
         chain12 <= {sdata12, chain12[11:1]}; edge_cnt12 <= edge_cnt12 + 1;
      end
   end

   // The chain must stall while a byte is waiting
   always @(negedge clock) begin
      if ((byte_valid && (scanclk || scanclkena)) || (bvalid12 && (sclk12 || sena12)))
         hold_viol <= hold_viol + 1;
   end

   task automatic chk(input logic [143:0] obs, input logic [143:0] exp, input string tag);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] crc_ref(input logic [143:0] bits, input int n);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         fb = c[15] ^ bits[i];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ 16'h1021;
      end
      return c;
   endfunction

   function automatic logic [143:0] counting_pattern();
      logic [143:0] p;
      for (int k = 0; k < 18; k++) p[8*k +: 8] = 8'(k + 1);
      return p;
   endfunction

   function automatic logic [143:0] rand_pattern();
      logic [143:0] p;
      for (int i = 0; i < 144; i++) p[i] = 1'($urandom_range(0, 1));
      return p;
   endfunction

   // One readback of the 144-bit chain. mode: 0 ready always, 1 ready every 3rd cycle, 2 random.
   task automatic do_read(input logic [143:0] pre, input int mode, input int abort_after,
                          input int extra_start, input string tag);
      int nb, cyc;
      logic seen, e_d, v_d, r_d, rdy;
      logic [7:0] expb;
      logic [15:0] crc_d;
      crc_d = 16'h0;
      load_val = pre; load_req = 1'b1; #1; load_req = 1'b0;
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
      chk(144'(busy), 144'(1'b1), {tag, "_busy"});
      nb = 0; cyc = 0; seen = 1'b0; e_d = 1'bx; v_d = 1'bx; r_d = 1'bx;
      while (!seen && cyc < 5000) begin
         @(negedge clock); cyc++;
         start = (cyc == extra_start);
         if (done) begin
            seen = 1'b1; e_d = error; v_d = byte_valid; r_d = scan_req;
`ifdef PLL_READBACK_CRC_EN
            crc_d = crc;
`endif
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc % 3 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         byte_ready = rdy;
         if (byte_valid && rdy) begin
            if (nb < 18) begin
               expb = pre[8*nb +: 8];
               chk(144'(byte_data), 144'(expb), $sformatf("%s_byte%0d", tag, nb));
            end
            nb++;
            if (nb == abort_after) gnt_en = 1'b0;
         end
      end
      start = 1'b0; byte_ready = 1'b0;
      chk(144'(seen), 144'(1'b1), {tag, "_done_seen"});
      if (abort_after > 0) begin
         chk(144'(e_d), 144'(1'b1), {tag, "_error"});
         chk(144'(nb), 144'(abort_after), {tag, "_nbytes"});
      end else begin
         chk(144'(e_d), 144'(1'b0), {tag, "_error"});
         chk(144'(nb), 144'(18), {tag, "_nbytes"});
         chk(144'(edge_cnt), 144'(144), {tag, "_edges"});
         chk(chain, pre, {tag, "_chain_restored"});
         if (mode == 0) chk(144'((cyc >= 576) && (cyc <= 640)), 144'(1'b1), {tag, "_latency"});
`ifdef PLL_READBACK_CRC_EN
         chk(144'(crc_d), 144'(crc_ref(pre, 144)), {tag, "_crc"});
`endif
      end
      chk(144'(v_d), 144'(1'b0), {tag, "_valid_at_done"});
      chk(144'(r_d), 144'(1'b0), {tag, "_req_at_done"});
      chk(144'(hold_viol), 144'(0), {tag, "_hold_stall"});
      @(negedge clock);
      chk(144'({busy, done}), 144'(2'b00), {tag, "_idle_after"});
      gnt_en = 1'b1;
   endtask

   task automatic do_read12(input logic [11:0] pre, input string tag);
      int nb, cyc;
      logic seen, e_d;
      logic [7:0] exp12 [2];
      logic [15:0] crc_d;
      crc_d = 16'h0;
      exp12[0] = pre[7:0];
      exp12[1] = {4'h0, pre[11:8]};
      load_val12 = pre; load_req12 = 1'b1; #1; load_req12 = 1'b0;
      @(negedge clock); start12 = 1'b1;
      @(negedge clock); start12 = 1'b0;
      nb = 0; cyc = 0; seen = 1'b0; e_d = 1'bx;
      while (!seen && cyc < 1000) begin
         @(negedge clock); cyc++;
         if (done12) begin
            seen = 1'b1; e_d = error12;
`ifdef PLL_READBACK_CRC_EN
            crc_d = crc12;
`endif
         end
         bready12 = 1'($urandom_range(0, 1));
         if (bvalid12 && bready12) begin
            if (nb < 2) chk(144'(bdata12), 144'(exp12[nb]), $sformatf("%s_byte%0d", tag, nb));
            nb++;
         end
      end
      bready12 = 1'b0;
      chk(144'(seen), 144'(1'b1), {tag, "_done_seen"});
      chk(144'(e_d), 144'(1'b0), {tag, "_error"});
      chk(144'(nb), 144'(2), {tag, "_nbytes"});
      chk(144'(edge_cnt12), 144'(12), {tag, "_edges"});
      chk(144'(chain12), 144'(pre), {tag, "_chain_restored"});
`ifdef PLL_READBACK_CRC_EN
      chk(144'(crc_d), 144'(crc_ref(144'(pre), 12)), {tag, "_crc"});
`endif
   endtask

   initial begin
      logic [143:0] pat;
      int   nb5, cyc5;
      logic found;
      reset_n = 1'b0; start = 1'b0; byte_ready = 1'b0; gnt_en = 1'b1; load_req = 1'b0;
      start12 = 1'b0; bready12 = 1'b0; load_req12 = 1'b0;
      load_val = '0; load_val12 = '0;
      pat = counting_pattern();
      #12;
      chk(144'({busy, done, error, scan_req, scanclk, scanclkena, scandata, byte_valid, byte_data}),
          144'(0), "reset_outputs");
`ifdef PLL_READBACK_CRC_EN
      chk(144'(crc), 144'(16'hFFFF), "reset_crc");
`endif
      @(negedge clock); reset_n = 1'b1;
      repeat (2) @(negedge clock);
      chk(144'({busy, scan_req, scanclk}), 144'(0), "idle_after_reset");

      do_read(pat, 0, 0, 0, "t1_counting");
      do_read(pat, 1, 0, 0, "t2_ready_1of3");
      for (int r = 0; r < 2; r++) do_read(rand_pattern(), 2, 0, 0, $sformatf("rand%0d", r));

      do_read12(12'hFFF, "t3_ones");
      do_read12(12'($urandom()), "t3_rand");

      do_read(pat, 0, 5, 0, "t4_abort");

      // Reset in the middle of a high scanclk phase, after a byte has been delivered
      load_val = pat; load_req = 1'b1; #1; load_req = 1'b0;
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0; byte_ready = 1'b1;
      nb5 = 0; cyc5 = 0; found = 1'b0;
      while (!found && cyc5 < 2000) begin
         @(negedge clock); cyc5++;
         if (byte_valid) nb5++;
         if (nb5 >= 1 && scanclk) found = 1'b1;
      end
      chk(144'(found), 144'(1'b1), "t5_reached_shift_hi");
      reset_n = 1'b0; #1;
      chk(144'({busy, done, error, scan_req, scanclk, scanclkena, scandata, byte_valid}), 144'(0),
          "t5_reset_ctrl");
      chk(144'(byte_data), 144'(0), "t5_reset_byte_data");
`ifdef PLL_READBACK_CRC_EN
      chk(144'(crc), 144'(16'hFFFF), "t5_reset_crc");
`endif
      @(negedge clock); reset_n = 1'b1; byte_ready = 1'b0;
      @(negedge clock);
      do_read(pat, 0, 0, 0, "t5_after_reset");

      do_read('0, 0, 0, 100, "t6_zeros_restart");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
